// File: rtl/alu_pkg.sv
// alu_pkg: op codes, NZCV flag bundle and FSM states shared by alu_stream.
package alu_pkg;
    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_SLT = 3'b101,
        OP_SRL = 3'b110,
        OP_MUL = 3'b111
    } alu_op_e;
    typedef struct packed {
        logic z;
        logic n;
        logic c;
        logic v;
    } alu_flags_t;
    typedef enum logic [1:0] {IDLE, MUL, DONE} alu_state_e;
endpackage

// File: rtl/alu_mul_seq.sv
// alu_mul_seq: shift-add unsigned multiplier; bit 0 is folded in on start, done_o flags the final step.
module alu_mul_seq #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start_i,
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    output logic               done_o,
    output logic [2*WIDTH-1:0] prod_o
);
    localparam int CW = $clog2(WIDTH);
    logic [2*WIDTH-1:0] acc_q, acc_d, mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    always_comb begin
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        if (start_i) begin
            acc_d    = a_i[0] ? {{WIDTH{1'b0}}, b_i} : '0;
            mcand_d  = {{(WIDTH-1){1'b0}}, b_i, 1'b0};
            mplier_d = a_i >> 1;
            cnt_d    = CW'(WIDTH-1);
        end else if (cnt_q != '0) begin
            acc_d    = acc_q + (mplier_q[0] ? mcand_q : '0);
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q - CW'(1);
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
        end else begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
        end
    end
    assign done_o = cnt_q == CW'(1);
    assign prod_o = acc_q;
endmodule

// File: rtl/alu_stream.sv
// alu_stream: registered valid/ready ALU with NZCV flags; define ALU_MUL_EN for the iterative multiply on op 111.
module alu_stream
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic [2:0]       alu_control,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] alu_result,
    output logic             zero,
    output logic             negative,
    output logic             carry,
    output logic             overflow,
    output logic             illegal
);
`ifdef ALU_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif
    localparam int SW = $clog2(WIDTH);
    alu_op_e            op;
    alu_state_e         state_q;
    alu_flags_t         flags_q, flags_d;
    logic [WIDTH:0]     sum, diff;
    logic [WIDTH-1:0]   res_c, res_d, res_q;
    logic [2*WIDTH-1:0] mul_prod;
    logic               c_c, v_c, ill_c, ill_d, ill_q, valid_d, valid_q;
    logic               accept, start_mul, load_sc, load_mul;
    assign op        = alu_op_e'(alu_control);
    assign in_ready  = (state_q == IDLE) && (!valid_q || out_ready);
    assign accept    = in_valid && in_ready;
    assign start_mul = accept && MUL_EN && (op == OP_MUL);
    assign load_sc   = accept && !start_mul;
    assign load_mul  = state_q == DONE;
    always_comb begin
        sum   = {1'b0, src_a} + {1'b0, src_b};
        diff  = {1'b0, src_a} - {1'b0, src_b};
        res_c = '0;
        c_c   = 1'b0;
        v_c   = 1'b0;
        ill_c = 1'b0;
        case (op)
            OP_ADD: begin
                res_c = sum[WIDTH-1:0];
                c_c   = sum[WIDTH];
                v_c   = (src_a[WIDTH-1] == src_b[WIDTH-1]) && (sum[WIDTH-1] != src_a[WIDTH-1]);
            end
            // carry on SUB is the no-borrow sense, i.e. A >= B unsigned
            OP_SUB: begin
                res_c = diff[WIDTH-1:0];
                c_c   = !diff[WIDTH];
                v_c   = (src_a[WIDTH-1] != src_b[WIDTH-1]) && (diff[WIDTH-1] != src_a[WIDTH-1]);
            end
            OP_AND: res_c = src_a & src_b;
            OP_OR:  res_c = src_a | src_b;
            OP_XOR: res_c = src_a ^ src_b;
            OP_SLT: res_c = {{(WIDTH-1){1'b0}}, $signed(src_a) < $signed(src_b)};
            OP_SRL: res_c = src_a >> src_b[SW-1:0];
            OP_MUL: ill_c = !MUL_EN;
        endcase
    end
    always_comb begin
        res_d   = load_sc ? res_c : load_mul ? mul_prod[WIDTH-1:0] : res_q;
        flags_d = (load_sc || load_mul)
                ? {~|res_d, res_d[WIDTH-1], load_sc ? c_c : |mul_prod[2*WIDTH-1:WIDTH], load_sc && v_c}
                : flags_q;
        ill_d   = load_sc ? ill_c : load_mul ? 1'b0 : ill_q;
        valid_d = load_sc || load_mul || (valid_q && !out_ready);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            res_q   <= '0;
            flags_q <= '0;
            ill_q   <= 1'b0;
        end else begin
            valid_q <= valid_d;
            res_q   <= res_d;
            flags_q <= flags_d;
            ill_q   <= ill_d;
        end
    end
`ifdef ALU_MUL_EN
    alu_state_e state_d;
    logic       mul_done;
    always_comb state_d = (state_q == IDLE) ? (start_mul ? MUL : IDLE)
                        : (state_q == MUL)  ? (mul_done ? DONE : MUL)
                        : IDLE;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end
    alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start_i (start_mul),
        .a_i     (src_a),
        .b_i     (src_b),
        .done_o  (mul_done),
        .prod_o  (mul_prod)
    );
`else
    assign state_q  = IDLE;
    assign mul_prod = '0;
`endif
    assign out_valid  = valid_q;
    assign alu_result = res_q;
    assign zero       = flags_q.z;
    assign negative   = flags_q.n;
    assign carry      = flags_q.c;
    assign overflow   = flags_q.v;
    assign illegal    = ill_q;
endmodule

// File: tb/tb_alu_stream.sv
// tb_alu_stream: directed and random stimulus against a transaction-level ALU model.
module tb_alu_stream;
    localparam int W = 8;
`ifdef ALU_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif
    typedef struct packed {
        logic         ill;
        logic         z;
        logic         n;
        logic         c;
        logic         v;
        logic [W-1:0] res;
    } exp_t;

    logic         clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
    logic         in_ready, out_valid, zero, negative, carry, overflow, illegal;
    logic [W-1:0] src_a = '0, src_b = '0, alu_result;
    logic [2:0]   alu_control = '0;
    exp_t         dut_out;
    int           checks = 0, errors = 0;
    int           m_cnt = 0;
    logic         m_valid = 1'b0, m_ready;
    exp_t         m_out = '0, m_pend = '0;

    always #5 clk = ~clk;

    alu_stream #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .src_a       (src_a),
        .src_b       (src_b),
        .alu_control (alu_control),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .alu_result  (alu_result),
        .zero        (zero),
        .negative    (negative),
        .carry       (carry),
        .overflow    (overflow),
        .illegal     (illegal)
    );

    assign dut_out = {illegal, zero, negative, carry, overflow, alu_result};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t mk(input logic i, z, n, c, v, input logic [W-1:0] r);
        return {i, z, n, c, v, r};
    endfunction

    // Reference ALU from plain integer arithmetic on signed/unsigned views of the operands.
    function automatic exp_t ref_alu(input int op, input int a, input int b);
        exp_t e;
        int   sa, sb, r;
        e  = '0;
        sa = (a >= 128) ? a - 256 : a;
        sb = (b >= 128) ? b - 256 : b;
        r  = 0;
        case (op)
            0: begin r = a + b; e.c = r > 255; e.v = (sa + sb > 127) || (sa + sb < -128); end
            1: begin r = a - b; e.c = a >= b;  e.v = (sa - sb > 127) || (sa - sb < -128); end
            2: r = a & b;
            3: r = a | b;
            4: r = a ^ b;
            5: r = (sa < sb) ? 1 : 0;
            6: r = a >> (b % W);
            default: begin
                if (MUL_EN) begin r = a * b; e.c = r > 255; end
                else e.ill = 1'b1;
            end
        endcase
        e.res = r[W-1:0];
        e.z   = e.res == '0;
        e.n   = e.res[W-1];
        return e;
    endfunction

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 7))
            0: return 8'h00;
            1: return 8'h01;
            2: return 8'h7F;
            3: return 8'h80;
            4: return 8'hFF;
            default: return 8'($urandom);
        endcase
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            m_cnt   = 0;
            m_valid = 1'b0;
            m_out   = '0;
            chk("reset out_valid", 32'(out_valid), 32'd0);
            chk("reset outputs", 32'(dut_out), 32'd0);
        end else begin
            m_ready = (m_cnt == 0) && (!m_valid || out_ready);
            chk("in_ready", 32'(in_ready), 32'(m_ready));
            chk("out_valid", 32'(out_valid), 32'(m_valid));
            if (m_valid) chk("outputs", 32'(dut_out), 32'(m_out));
            if (m_cnt > 0) begin
                m_cnt--;
                if (m_cnt == 0) begin
                    m_out   = m_pend;
                    m_valid = 1'b1;
                end
            end else if (in_valid && m_ready) begin
                if (MUL_EN && alu_control == 3'd7) begin
                    m_cnt   = W;
                    m_pend  = ref_alu(int'(alu_control), int'(src_a), int'(src_b));
                    m_valid = 1'b0;
                end else begin
                    m_out   = ref_alu(int'(alu_control), int'(src_a), int'(src_b));
                    m_valid = 1'b1;
                end
            end else if (out_ready) begin
                m_valid = 1'b0;
            end
        end
    end

    task automatic issue(input int op, input int a, input int b);
        int n = 0;
        @(posedge clk); #1;
        in_valid = 1'b1; alu_control = 3'(op); src_a = 8'(a); src_b = 8'(b);
        @(negedge clk);
        while (!in_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("accept ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0; alu_control = 3'($urandom); src_a = 8'($urandom); src_b = 8'($urandom);
    endtask

    task automatic expect_out(input string name, input int lat, input exp_t e);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid && n < 40);
        chk({name, " latency"}, 32'(n), 32'(lat));
        chk({name, " value"}, 32'(dut_out), 32'(e));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation still running (got timeout, expected $finish)");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk);
        @(posedge clk); #1 rst_n = 1'b1;
        chk("model ADD", 32'(ref_alu(0, 5, 10)), 32'(mk(0, 0, 0, 0, 0, 8'h0F)));
        chk("model SUB ovf", 32'(ref_alu(1, 128, 1)), 32'(mk(0, 0, 0, 1, 1, 8'h7F)));
        chk("model SLT", 32'(ref_alu(5, 255, 1)), 32'(mk(0, 0, 0, 0, 0, 8'h01)));
`ifdef ALU_MUL_EN
        chk("model MUL", 32'(ref_alu(7, 16, 16)), 32'(mk(0, 1, 0, 1, 0, 8'h00)));
`else
        chk("model MUL off", 32'(ref_alu(7, 16, 16)), 32'(mk(1, 1, 0, 0, 0, 8'h00)));
`endif
        issue(0, 8'h05, 8'h0A); expect_out("ADD 05+0A", 1, mk(0, 0, 0, 0, 0, 8'h0F));
        issue(1, 8'h05, 8'h0A); expect_out("SUB 05-0A", 1, mk(0, 0, 1, 0, 0, 8'hFB));
        issue(1, 8'h80, 8'h01); expect_out("SUB 80-01", 1, mk(0, 0, 0, 1, 1, 8'h7F));
        issue(0, 8'hFF, 8'h01); expect_out("ADD FF+01", 1, mk(0, 1, 0, 1, 0, 8'h00));
        issue(5, 8'hFF, 8'h01); expect_out("SLT FF,01", 1, mk(0, 0, 0, 0, 0, 8'h01));
        issue(6, 8'h80, 8'h03); expect_out("SRL 80,03", 1, mk(0, 0, 0, 0, 0, 8'h10));
`ifdef ALU_MUL_EN
        issue(7, 8'h0F, 8'h11); expect_out("MUL 0F*11", W + 1, mk(0, 0, 1, 0, 0, 8'hFF));
        issue(7, 8'h10, 8'h10); expect_out("MUL 10*10", W + 1, mk(0, 1, 0, 1, 0, 8'h00));
`else
        issue(7, 8'h0F, 8'h11); expect_out("MUL disabled", 1, mk(1, 1, 0, 0, 0, 8'h00));
`endif
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            in_valid = (i < 4); alu_control = 3'd0; src_a = 8'(i); src_b = 8'h20;
            @(negedge clk);
            if (i > 0) begin
                chk("b2b valid", 32'(out_valid), 32'd1);
                chk("b2b result", 32'(alu_result), 32'(8'h20 + 8'(i - 1)));
            end
            if (i < 4) chk("b2b ready", 32'(in_ready), 32'd1);
        end
        @(posedge clk); #1;
        out_ready = 1'b0; in_valid = 1'b1; alu_control = 3'd2; src_a = 8'h0F; src_b = 8'hF0;
        @(posedge clk); #1 alu_control = 3'd3;
        repeat (5) begin
            @(negedge clk);
            chk("bp valid", 32'(out_valid), 32'd1);
            chk("bp hold", 32'(dut_out), 32'(mk(0, 1, 0, 0, 0, 8'h00)));
            chk("bp in_ready", 32'(in_ready), 32'd0);
        end
        @(posedge clk); #1 out_ready = 1'b1;
        @(negedge clk); chk("bp ready on out_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1 in_valid = 1'b0;
        @(negedge clk);
        chk("bp queued OR valid", 32'(out_valid), 32'd1);
        chk("bp queued OR", 32'(dut_out), 32'(mk(0, 0, 1, 0, 0, 8'hFF)));
        issue(7, 8'h0F, 8'h11);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        chk("mid-op reset valid", 32'(out_valid), 32'd0);
        chk("mid-op reset outputs", 32'(dut_out), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        issue(0, 8'h01, 8'h01); expect_out("ADD after reset", 1, mk(0, 0, 0, 0, 0, 8'h02));
        repeat (W + 2) @(negedge clk);
        chk("no stale product", 32'(out_valid), 32'd0);
        for (int n = 0; n < 3000; n++) begin
            @(posedge clk); #1;
            in_valid    = $urandom_range(0, 3) != 0;
            alu_control = 3'($urandom_range(0, 7));
            src_a       = pick();
            src_b       = pick();
            out_ready   = $urandom_range(0, 3) != 0;
        end
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (W + 4) @(posedge clk);
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
